led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Multi-channel LED pattern generator; parametrised successor to the single free-running LED blinker.
//  Drives NUM_LEDS board LEDs. Each channel is independently OFF/ON/BLINK/PWM/BREATHE, configured
//  through a valid/ready write port from the control logic. Shared prescaler and PWM counter set timing.
// PARAMETERS
//  NUM_LEDS        8   number of LED channels (>=1)
//  CHAN_WIDTH      4   width of cfg_chan; 2**CHAN_WIDTH >= NUM_LEDS required
//  PRESCALE_WIDTH  16  width of prescale divider input/counter
//  PWM_WIDTH       8   PWM counter/duty width; PWM period = 2**PWM_WIDTH ticks
//  DIV_WIDTH       8   blink divider width
// PORTS
//  clk        in   1               system clock; single clock domain
//  rst        in   1               synchronous, active-high reset
//  prescale   in   PRESCALE_WIDTH  tick every prescale+1 clk cycles (quasi-static)
//  cfg_valid  in   1               config write request
//  cfg_ready  out  1               block can accept config; write happens on cfg_valid && cfg_ready
//  cfg_chan   in   CHAN_WIDTH      target channel
//  cfg_mode   in   3               0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE, 5-7 reserved (= OFF)
//  cfg_div    in   DIV_WIDTH       BLINK: toggle every cfg_div+1 PWM periods
//  cfg_duty   in   PWM_WIDTH       PWM: duty; BREATHE: peak level
//  tick       out  1               registered one-cycle prescaler strobe (debug/shared timebase)
//  led        out  NUM_LEDS        registered LED outputs
// BEHAVIOUR
//  Reset (rst=1 at an edge): led=0, tick=0, cfg_ready=0, all channels mode OFF, div=0, duty=0,
//   prescale/PWM/blink counters=0, breathe level=0 dir=up. cfg_valid ignored while in reset.
//   cfg_ready is registered: 1 from the first edge with rst=0; then stays 1 (no backpressure).
//  Prescaler: pre_cnt increments each clk; when pre_cnt >= prescale: tick=1 next cycle, pre_cnt<=0.
//   The >= compare makes a mid-count decrease of prescale safe. prescale=0 -> tick every cycle.
//  PWM counter: pwm_cnt+1 on each tick, wraps 2**PWM_WIDTH-1 -> 0; pwm_wrap = tick && pwm_cnt==max.
//  Config: accepted at edge E; mode/div/duty of cfg_chan updated at E; that channel's blink_cnt,
//   blink_state, breathe level/dir cleared at E. cfg_chan >= NUM_LEDS: accepted, no effect.
//   led reflects the new config after edge E+1 (one-cycle output latency).
//  Channel output (registered, evaluated each edge):
//   OFF: 0.  ON: 1.  PWM: pwm_cnt < duty (duty=0 -> always 0; max -> high 2**PWM_WIDTH-1 of 2**PWM_WIDTH).
//   BLINK: on pwm_wrap: if blink_cnt==div {blink_state toggles, blink_cnt<=0} else blink_cnt+1; led=blink_state
//    (starts 0 after config).
//   BREATHE: on pwm_wrap: dir up: level>=peak ? dir<=down : level+1; dir down: level==0 ? dir<=up : level-1.
//    led = pwm_cnt < level. peak=0 -> constant 0. Peak lowered below level: ramps down at next wraps.
//  Width rules: all counters unsigned, wrap modulo own width; no saturation except as stated above.
//  Simultaneous: config write and pwm_wrap on same edge for same channel -> config write wins (state cleared).
//  Reset mid-operation: rst overrides all; all outputs 0 after that edge regardless of cfg_valid.
// STRUCTURE
//  Package led_pattern_pkg: mode localparams/enum (MODE_OFF..MODE_BREATHE), MODE_WIDTH=3.
//  Sub-module led_channel (one instance per channel in generate loop): holds mode/div/duty regs,
//   blink and breathe state, output flop; inputs pwm_cnt, pwm_wrap, write strobe + cfg fields.
//  Top: prescaler, PWM counter, cfg_ready flop, cfg_chan decode into per-channel write strobes.
// TESTING (NUM_LEDS=4, CHAN_WIDTH=3, PWM_WIDTH=4, DIV_WIDTH=4 unless stated)
//  1 rst=1 3 cycles with cfg_valid=1 mode ON chan 0 -> led=0, cfg_ready=0, tick=0; cfg_ready=1 first edge after rst=0; led[0] stays 0.
//  2 prescale=3 -> tick high 1 of every 4 cycles; change to 0 mid-count -> tick every cycle from next edge.
//  3 prescale=0, chan 1 PWM duty=5 -> led[1] high exactly 5 of every 16 cycles; duty=0 -> never high.
//  4 prescale=0, chan 2 BLINK div=2 -> led[2] first rises after 3rd pwm_wrap, then toggles every 48 cycles.
//  5 prescale=0, chan 3 BREATHE peak=3 -> per-period high counts 0,1,2,3,3,2,1,0,0,1,... (level update lag).
//  6 write cfg_chan=7 -> accepted, no led change; rst mid-BLINK -> led=0 next edge, channel OFF after release.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared mode encodings and breathe direction type for the LED pattern generator.
package led_pattern_pkg;
  localparam int MODE_WIDTH = 3;

  typedef enum logic [MODE_WIDTH-1:0] {
    MODE_OFF     = 3'd0,
    MODE_ON      = 3'd1,
    MODE_BLINK   = 3'd2,
    MODE_PWM     = 3'd3,
    MODE_BREATHE = 3'd4
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;
endpackage

// File: rtl/led_channel.sv
// One LED channel: config registers, blink/breathe state and a registered output.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int PWM_WIDTH = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PWM_WIDTH-1:0]  pwm_cnt,
  input  logic                  pwm_wrap,
  input  logic                  wr,
  input  logic [MODE_WIDTH-1:0] wr_mode,
  input  logic [DIV_WIDTH-1:0]  wr_div,
  input  logic [PWM_WIDTH-1:0]  wr_duty,
  output logic                  led
);
  logic [MODE_WIDTH-1:0] mode;
  logic [DIV_WIDTH-1:0]  div;
  logic [PWM_WIDTH-1:0]  duty;
  logic [DIV_WIDTH-1:0]  blink_cnt;
  logic                  blink_state;
  logic [PWM_WIDTH-1:0]  level;
  dir_e                  dir;
  logic                  led_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      mode        <= MODE_OFF;
      div         <= '0;
      duty        <= '0;
      blink_cnt   <= '0;
      blink_state <= 1'b0;
      level       <= '0;
      dir         <= DIR_UP;
      led         <= 1'b0;
    end else begin
      led <= led_nxt;
      // A write restarts the pattern and takes priority over a coincident wrap.
      if (wr) begin
        mode        <= wr_mode;
        div         <= wr_div;
        duty        <= wr_duty;
        blink_cnt   <= '0;
        blink_state <= 1'b0;
        level       <= '0;
        dir         <= DIR_UP;
      end else if (pwm_wrap) begin
        if (blink_cnt == div) begin
          blink_state <= ~blink_state;
          blink_cnt   <= '0;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
        if (dir == DIR_UP) begin
          if (level >= duty) dir <= DIR_DOWN;
          else               level <= level + 1'b1;
        end else begin
          if (level == '0) dir <= DIR_UP;
          else             level <= level - 1'b1;
        end
      end
    end
  end

  // Reserved modes fall through to the default and stay dark.
  always_comb begin
    led_nxt = 1'b0;
    case (mode)
      MODE_ON:      led_nxt = 1'b1;
      MODE_BLINK:   led_nxt = blink_state;
      MODE_PWM:     led_nxt = (pwm_cnt < duty);
      MODE_BREATHE: led_nxt = (pwm_cnt < level);
      default:      led_nxt = 1'b0;
    endcase
  end
endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler/PWM timebase, per-channel pattern engines.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS       = 8,
  parameter int CHAN_WIDTH     = 4,
  parameter int PRESCALE_WIDTH = 16,
  parameter int PWM_WIDTH      = 8,
  parameter int DIV_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CHAN_WIDTH-1:0]     cfg_chan,
  input  logic [MODE_WIDTH-1:0]     cfg_mode,
  input  logic [DIV_WIDTH-1:0]      cfg_div,
  input  logic [PWM_WIDTH-1:0]      cfg_duty,
  output logic                      tick,
  output logic [NUM_LEDS-1:0]       led
);
  logic [PRESCALE_WIDTH-1:0] pre_cnt;
  logic [PWM_WIDTH-1:0]      pwm_cnt;
  logic                      pwm_wrap;
  logic                      cfg_wr;

  // Compare with >= so lowering prescale mid-count cannot strand the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt >= prescale) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_ready <= 1'b0;
    else     cfg_ready <= 1'b1;
  end

  assign pwm_wrap = tick && (pwm_cnt == '1);
  assign cfg_wr   = cfg_valid && cfg_ready;

  // Out-of-range channel numbers match no instance and are silently dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    localparam logic [CHAN_WIDTH-1:0] IDX = CHAN_WIDTH'(i);
    logic wr;
    assign wr = cfg_wr && (cfg_chan == IDX);

    led_channel #(
      .PWM_WIDTH(PWM_WIDTH),
      .DIV_WIDTH(DIV_WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .pwm_cnt (pwm_cnt),
      .pwm_wrap(pwm_wrap),
      .wr      (wr),
      .wr_mode (cfg_mode),
      .wr_div  (cfg_div),
      .wr_duty (cfg_duty),
      .led     (led[i])
    );
  end
endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen (4 channels, 4-bit PWM).
module tb_led_pattern_gen;
  localparam int NUM_LEDS = 4, CHAN_WIDTH = 3, PRESCALE_WIDTH = 16, PWM_WIDTH = 4, DIV_WIDTH = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [PRESCALE_WIDTH-1:0] prescale = '0;
  logic                      cfg_valid = 1'b0;
  logic                      cfg_ready;
  logic [CHAN_WIDTH-1:0]     cfg_chan = '0;
  logic [2:0]                cfg_mode = '0;
  logic [DIV_WIDTH-1:0]      cfg_div = '0;
  logic [PWM_WIDTH-1:0]      cfg_duty = '0;
  logic                      tick;
  logic [NUM_LEDS-1:0]       led;

  int tests = 0;
  int fails = 0;
  int k = 0;

  led_pattern_gen #(
    .NUM_LEDS(NUM_LEDS), .CHAN_WIDTH(CHAN_WIDTH), .PRESCALE_WIDTH(PRESCALE_WIDTH),
    .PWM_WIDTH(PWM_WIDTH), .DIV_WIDTH(DIV_WIDTH)
  ) dut (
    .clk(clk), .rst(rst), .prescale(prescale), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_div(cfg_div), .cfg_duty(cfg_duty),
    .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; samples taken afterwards reflect state after that edge.
  task automatic step();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Leaves the bench just after edge R (first edge with rst=0), k=0.
  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    k = 0;
  endtask

  // Returns just after the accepting edge.
  task automatic cfg(input logic [2:0] ch, input logic [2:0] m, input logic [3:0] dv, input logic [3:0] dt);
    cfg_valid = 1'b1; cfg_chan = ch; cfg_mode = m; cfg_div = dv; cfg_duty = dt;
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    int cnt;
    int exp_br[10];
    bit seen;
    exp_br = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1};

    // 1: writes during reset are ignored, ready follows reset release
    prescale = 0;
    rst = 1'b1; cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_mode = 3'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("rst_led%0d", i), led, 0);
      chk($sformatf("rst_ready%0d", i), cfg_ready, 0);
      chk($sformatf("rst_tick%0d", i), tick, 0);
    end
    rst = 1'b0;
    step();
    chk("ready_after_rst", cfg_ready, 1);
    chk("led_at_release", led, 0);
    cfg_valid = 1'b0;
    step(); chk("led0_no_write_a", led[0], 0);
    step(); chk("led0_no_write_b", led[0], 0);

    // 2: prescaler period and mid-count decrease
    prescale = 3;
    do_reset();
    for (int i = 0; i <= 12; i++) begin
      if (i != 0) step();
      chk($sformatf("tick_ps3_k%0d", k), tick, (k % 4 == 3) ? 1 : 0);
    end
    prescale = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("tick_ps0_k%0d", k), tick, 1);
    end

    // 3: PWM duty 5, 0, max
    do_reset();
    cfg(3'd1, 3'd3, 4'd0, 4'd5);
    cnt = 0;
    for (int i = 0; i < 32; i++) begin step(); cnt += led[1]; end
    chk("pwm_duty5_cnt32", cnt, 10);
    cfg(3'd1, 3'd3, 4'd0, 4'd0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(); cnt += led[1]; end
    chk("pwm_duty0_cnt16", cnt, 0);
    cfg(3'd1, 3'd3, 4'd0, 4'd15);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin step(); cnt += led[1]; end
    chk("pwm_duty15_cnt16", cnt, 15);

    // 4: BLINK div=2, write accepted at k=1; toggles at wraps 3, 6, 9
    do_reset();
    cfg(3'd2, 3'd2, 4'd2, 4'd0);
    while (k < 150) begin
      step();
      if (k == 48)  chk("blink_k48", led[2], 0);
      if (k == 49)  chk("blink_k49", led[2], 1);
      if (k == 96)  chk("blink_k96", led[2], 1);
      if (k == 97)  chk("blink_k97", led[2], 0);
      if (k == 144) chk("blink_k144", led[2], 0);
      if (k == 145) chk("blink_k145", led[2], 1);
    end

    // 5: BREATHE peak=3, per-period high counts
    do_reset();
    cfg(3'd3, 3'd4, 4'd0, 4'd3);
    for (int p = 0; p < 10; p++) begin
      cnt = 0;
      for (int j = 0; j < 16; j++) begin
        if (p != 0 || j != 0) step();
        cnt += led[3];
      end
      chk($sformatf("breathe_p%0d", p), cnt, exp_br[p]);
    end

    // 6: out-of-range channel, latency, reserved mode, reset mid-blink
    do_reset();
    cfg(3'd7, 3'd1, 4'd0, 4'd0);
    cnt = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt += (led != 0); end
    chk("chan7_no_effect", cnt, 0);
    chk("chan7_ready", cfg_ready, 1);
    cfg(3'd0, 3'd1, 4'd0, 4'd0);
    chk("on_latency_E", led[0], 0);
    step(); chk("on_E1", led[0], 1);
    cfg(3'd0, 3'd5, 4'd0, 4'd0);
    chk("rsvd_latency_E", led[0], 1);
    step(); chk("rsvd_E1", led[0], 0);
    cfg(3'd0, 3'd2, 4'd0, 4'd0);
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin step(); seen = led[0]; end
    chk("blink_rose_before_rst", seen, 1);
    rst = 1'b1;
    step();
    chk("midrst_led", led, 0);
    chk("midrst_tick", tick, 0);
    chk("midrst_ready", cfg_ready, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin step(); cnt += led[0]; end
    chk("off_after_rst", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
